// File: rtl/vector_page_pkg.sv
// Shared definitions for vector_page: default parameters, FSM state type and
// the default interrupt-vector table.
package vector_page_pkg;

  localparam int VP_ADDR_W    = 6;
  localparam int VP_DATA_W    = 8;
  localparam int VP_VEC_BASE  = 48;
  localparam int VP_VEC_COUNT = 16;
  localparam int VP_TABLE_LEN = 16;

  // Entry 0 sits in the least significant byte.
  localparam logic [127:0] VP_VEC_TABLE = 128'h27A0_0901_0601_0C01_0F01_0301_0001_81A6;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } vp_state_e;

  function automatic logic [7:0] vp_table_entry(input logic [3:0] idx);
    return VP_VEC_TABLE[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/vector_page_rom.sv
// Combinational default word for a vector-region index; indices past the
// table are zero and the word is zero-extended to DATA_W.
module vector_page_rom
  import vector_page_pkg::*;
#(
  parameter int ADDR_W = VP_ADDR_W,
  parameter int DATA_W = VP_DATA_W
) (
  input  logic [ADDR_W-1:0] idx_i,
  output logic [DATA_W-1:0] word_o
);

  // Table lookup with zero fill past the last defined entry.
  always_comb begin
    word_o = {DATA_W{1'b0}};
    if ({1'b0, idx_i} < (ADDR_W+1)'(VP_TABLE_LEN)) begin
      word_o = DATA_W'(vp_table_entry(idx_i[3:0]));
    end else begin
      word_o = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/vector_page.sv
// Single-port word memory whose vector region is loaded from a default table
// after reset or reload. Optional write protection: VECTOR_PAGE_WP_EN.
module vector_page
  import vector_page_pkg::*;
#(
  parameter int ADDR_W    = VP_ADDR_W,
  parameter int DATA_W    = VP_DATA_W,
  parameter int VEC_BASE  = VP_VEC_BASE,
  parameter int VEC_COUNT = VP_VEC_COUNT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              cs,
  input  logic              reload,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              wp_hit
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] VEC_LO   = (ADDR_W+1)'(VEC_BASE);
  localparam logic [ADDR_W:0] VEC_HI   = (ADDR_W+1)'(VEC_BASE + VEC_COUNT);

  logic [DATA_W-1:0] mem_q [DEPTH];
  vp_state_e         state_q;
  logic [ADDR_W:0]   ptr_q;
  logic [ADDR_W:0]   ptr_d;
  logic [DATA_W-1:0] dout_q;
  logic              busy_q;
  logic              wp_hit_q;

  logic [ADDR_W-1:0] vec_idx_s;
  logic [DATA_W-1:0] rom_word_s;
  logic              cpu_req_s;
  logic              wp_block_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  function automatic logic in_vec(input logic [ADDR_W:0] a);
    return (a >= VEC_LO) && (a < VEC_HI);
  endfunction

  assign vec_idx_s = ptr_q[ADDR_W-1:0] - VEC_LO[ADDR_W-1:0];

  vector_page_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .idx_i  (vec_idx_s),
    .word_o (rom_word_s)
  );

  // Write-port arbitration: the loader owns the port in INIT, the CPU in RUN.
  always_comb begin
    ptr_d       = ptr_q + (ADDR_W+1)'(1);
    cpu_req_s   = (state_q == ST_RUN) && !we && !cs;
`ifdef VECTOR_PAGE_WP_EN
    wp_block_s  = cpu_req_s && in_vec({1'b0, addr});
`else
    wp_block_s  = 1'b0;
`endif
    mem_we_s    = 1'b0;
    mem_waddr_s = addr;
    mem_wdata_s = din;
    if (state_q == ST_INIT) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = ptr_q[ADDR_W-1:0];
      mem_wdata_s = in_vec(ptr_q) ? rom_word_s : {DATA_W{1'b0}};
    end else if (cpu_req_s && !wp_block_s) begin
      mem_we_s    = 1'b1;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Storage array; deliberately not reset, the loader rewrites every word.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Load/run sequencer with registered read data and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      ptr_q    <= {(ADDR_W+1){1'b0}};
      dout_q   <= {DATA_W{1'b0}};
      busy_q   <= 1'b1;
      wp_hit_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q    <= ptr_d;
          dout_q   <= {DATA_W{1'b0}};
          wp_hit_q <= 1'b0;
          if (ptr_q == LAST_PTR) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          dout_q   <= mem_q[addr];
          wp_hit_q <= wp_block_s;
          if (reload) begin
            state_q <= ST_INIT;
            ptr_q   <= {(ADDR_W+1){1'b0}};
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_INIT;
          ptr_q    <= {(ADDR_W+1){1'b0}};
          dout_q   <= {DATA_W{1'b0}};
          busy_q   <= 1'b1;
          wp_hit_q <= 1'b0;
        end
      endcase
    end
  end

  assign dout   = dout_q;
  assign busy   = busy_q;
  assign wp_hit = wp_hit_q;

endmodule

// File: tb/tb_vector_page.sv
// Directed self-checking bench for vector_page (default geometry plus an
// ADDR_W=8 / DATA_W=16 instance); expectations follow VECTOR_PAGE_WP_EN.
module tb_vector_page;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  addr;
  logic [7:0]  din;
  logic        we, cs, reload;
  logic [7:0]  dout;
  logic        busy, wp_hit;

  logic [7:0]  addr2;
  logic [15:0] din2;
  logic [15:0] dout2;
  logic        busy2, wp_hit2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vector_page dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .we(we), .cs(cs),
    .reload(reload), .dout(dout), .busy(busy), .wp_hit(wp_hit)
  );

  vector_page #(.ADDR_W(8), .DATA_W(16), .VEC_BASE(240), .VEC_COUNT(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .addr(addr2), .din(din2), .we(1'b1), .cs(1'b1),
    .reload(1'b0), .dout(dout2), .busy(busy2), .wp_hit(wp_hit2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
    addr = a;
    @(posedge clk); @(negedge clk);
    check_eq(tag, {24'h0, dout}, {24'h0, exp});
  endtask

  task automatic rd2_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    addr2 = a;
    @(posedge clk); @(negedge clk);
    check_eq(tag, {16'h0, dout2}, {16'h0, exp});
  endtask

  // Count INIT clocks until busy drops; pokes a CPU write at 0x01 mid-load.
  task automatic load_wait(input int reload_at, input bit track2, output int n1, output int n2);
    bit done1, done2;
    n1 = 0; n2 = 0; done1 = 1'b0; done2 = !track2;
    for (int k = 1; k <= 400 && !(done1 && done2); k++) begin
      @(posedge clk); @(negedge clk);
      reload = (k == reload_at);
      if (k >= 5 && k <= 8) begin
        addr = 6'h01; din = 8'hEE; we = 1'b0; cs = 1'b0;
      end else begin
        we = 1'b1; cs = 1'b1;
      end
      if (k == 6) check_eq("init_dout_zero", {24'h0, dout}, 32'h0);
      if (!busy && !done1) begin n1 = k; done1 = 1'b1; end
      if (!busy2 && !done2) begin n2 = k; done2 = 1'b1; end
    end
    reload = 1'b0; we = 1'b1; cs = 1'b1;
  endtask

  initial begin
    int n1, n2;
    reset_n = 1'b0; addr = 6'h00; din = 8'h00; we = 1'b1; cs = 1'b1; reload = 1'b0;
    addr2 = 8'h00; din2 = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'h0, busy}, 32'h1);
    check_eq("rst_dout", {24'h0, dout}, 32'h0);
    check_eq("rst_wp_hit", {31'h0, wp_hit}, 32'h0);

    reset_n = 1'b1;
    load_wait(0, 1'b1, n1, n2);
    check_eq("load_len", n1, 32'd64);
    check_eq("load_len_w8", n2, 32'd256);
    rd_chk("vec_3e", 6'h3E, 8'hA0);
    rd_chk("vec_3f", 6'h3F, 8'h27);
    rd_chk("word_00", 6'h00, 8'h00);
    rd_chk("vec_30", 6'h30, 8'hA6);
    rd_chk("init_write_ignored", 6'h01, 8'h00);
    rd2_chk("w8_f0", 8'hF0, 16'h00A6);
    rd2_chk("w8_ff", 8'hFF, 16'h0027);
    rd2_chk("w8_f1", 8'hF1, 16'h0081);

    // Write with same-cycle read, then read back.
    addr = 6'h05; din = 8'h5A; we = 1'b0; cs = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("wr_same_cycle_old", {24'h0, dout}, 32'h0);
    we = 1'b1; cs = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("wr_readback", {24'h0, dout}, 32'h5A);

    // Vector-region write.
    addr = 6'h38; din = 8'hFF; we = 1'b0; cs = 1'b0;
    @(posedge clk); @(negedge clk);
    we = 1'b1; cs = 1'b1;
    check_eq("vec_wr_old", {24'h0, dout}, 32'h01);
`ifdef VECTOR_PAGE_WP_EN
    check_eq("wp_hit_pulse", {31'h0, wp_hit}, 32'h1);
`else
    check_eq("wp_hit_pulse", {31'h0, wp_hit}, 32'h0);
`endif
    @(posedge clk); @(negedge clk);
    check_eq("wp_hit_clear", {31'h0, wp_hit}, 32'h0);
`ifdef VECTOR_PAGE_WP_EN
    check_eq("vec_wr_result", {24'h0, dout}, 32'h01);
`else
    check_eq("vec_wr_result", {24'h0, dout}, 32'hFF);
`endif

    // Reload with a late reload pulse that must be ignored.
    addr = 6'h10; din = 8'h77; we = 1'b0; cs = 1'b0;
    @(posedge clk); @(negedge clk);
    we = 1'b1; cs = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("wr_10", {24'h0, dout}, 32'h77);
    reload = 1'b1; addr = 6'h20; din = 8'h44; we = 1'b0; cs = 1'b0;
    @(posedge clk); @(negedge clk);
    reload = 1'b0; we = 1'b1; cs = 1'b1;
    check_eq("reload_busy", {31'h0, busy}, 32'h1);
    load_wait(10, 1'b0, n1, n2);
    check_eq("reload_len", n1, 32'd64);
    rd_chk("reload_10", 6'h10, 8'h00);
    rd_chk("reload_30", 6'h30, 8'hA6);
    rd_chk("reload_05", 6'h05, 8'h00);
    rd_chk("reload_20", 6'h20, 8'h00);
    rd_chk("reload_38", 6'h38, 8'h01);

    // Async reset in the middle of a load.
    reload = 1'b1;
    @(posedge clk); @(negedge clk);
    reload = 1'b0;
    repeat (20) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midinit_rst_busy", {31'h0, busy}, 32'h1);
    check_eq("midinit_rst_dout", {24'h0, dout}, 32'h0);
    check_eq("midinit_rst_wp", {31'h0, wp_hit}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    load_wait(0, 1'b0, n1, n2);
    check_eq("midinit_reload_len", n1, 32'd64);
    rd_chk("midinit_3f", 6'h3F, 8'h27);

    // Async reset while reading in RUN clears dout without a clock edge.
    rd_chk("run_30", 6'h30, 8'hA6);
    #2 reset_n = 1'b0;
    #1;
    check_eq("run_rst_dout", {24'h0, dout}, 32'h0);
    check_eq("run_rst_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    load_wait(0, 1'b0, n1, n2);
    check_eq("run_reload_len", n1, 32'd64);
    rd_chk("final_3e", 6'h3E, 8'hA0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
